// File: rtl/mux_extend_pipe.sv
// mux_extend_pipe: selects one of NUM_SRC narrow operands, widens it to OUT_W
// using a per-beat extension mode, and registers the result behind a
// valid/ready handshake with a 2-entry skid buffer (main + skid).
module mux_extend_pipe #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [NUM_SRC*IN_W-1:0] i_src_data,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [1:0]              i_mode,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [OUT_W-1:0]        o_out_data,
  output logic                    o_out_sel_err
);

  localparam logic [1:0] MODE_ZEXT  = 2'b00;
  localparam logic [1:0] MODE_SEXT  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BROFF = 2'b11;

  // Storage: main drives the output, skid catches one beat while main stalls.
  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic             r_main_err;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic             r_skid_err;

  logic             w_main_valid_nxt;
  logic [OUT_W-1:0] w_main_data_nxt;
  logic             w_main_err_nxt;
  logic             w_skid_valid_nxt;
  logic [OUT_W-1:0] w_skid_data_nxt;
  logic             w_skid_err_nxt;

  logic [IN_W-1:0]  w_src;
  logic             w_sel_err;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_xfer;

  // Source select; an out-of-range index yields a zero operand and flags the beat.
  always_comb begin
    w_src     = '0;
    w_sel_err = (32'(i_sel) >= NUM_SRC);
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_src = i_src_data[k*IN_W +: IN_W];
      end
    end
  end

  // Extension by mode; the branch-offset mode drops bits shifted past OUT_W.
  always_comb begin
    w_sext = {{(OUT_W-IN_W){w_src[IN_W-1]}}, w_src};
    w_ext  = '0;
    unique case (i_mode)
      MODE_ZEXT:  w_ext = {{(OUT_W-IN_W){1'b0}}, w_src};
      MODE_SEXT:  w_ext = w_sext;
      MODE_UPPER: w_ext = {w_src, {(OUT_W-IN_W){1'b0}}};
      MODE_BROFF: w_ext = {w_sext[OUT_W-3:0], 2'b00};
      default:    w_ext = '0;
    endcase
  end

  assign o_in_ready    = !r_skid_valid;
  assign o_out_valid   = r_main_valid;
  assign o_out_data    = r_main_data;
  assign o_out_sel_err = r_main_err;

  assign w_accept = i_in_valid & !r_skid_valid;
  assign w_xfer   = r_main_valid & i_out_ready;

  // Next-state of the EMPTY/ONE/FULL storage; order is strictly main then skid.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_main_err_nxt   = r_main_err;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_err_nxt   = r_skid_err;
    if (!r_main_valid) begin
      if (w_accept) begin
        w_main_valid_nxt = 1'b1;
        w_main_data_nxt  = w_ext;
        w_main_err_nxt   = w_sel_err;
      end
    end else if (!r_skid_valid) begin
      if (w_xfer && w_accept) begin
        w_main_data_nxt = w_ext;
        w_main_err_nxt  = w_sel_err;
      end else if (w_xfer) begin
        w_main_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_data_nxt  = w_ext;
        w_skid_err_nxt   = w_sel_err;
      end
    end else if (w_xfer) begin
      w_main_data_nxt  = r_skid_data;
      w_main_err_nxt   = r_skid_err;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = '0;
      w_skid_err_nxt   = 1'b0;
    end
  end

  // State registers; reset discards any buffered beats immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_main_err   <= w_main_err_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_err   <= w_skid_err_nxt;
    end
  end

endmodule

// File: tb/tb_mux_extend_pipe.sv
// Self-checking bench for mux_extend_pipe: directed steps plus a random
// valid/ready run checked against a queue-based reference.
module tb_mux_extend_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Instance A: NUM_SRC=2
  logic        in_valid, in_ready, out_valid, out_ready, out_sel_err;
  logic [31:0] src_data, out_data;
  logic [0:0]  sel;
  logic [1:0]  mode;

  // Instance B: NUM_SRC=3 for out-of-range select
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sel_err;
  logic [47:0] b_src_data;
  logic [31:0] b_out_data;
  logic [1:0]  b_sel, b_mode;

  int n_checks = 0;
  int n_errors = 0;

  mux_extend_pipe #(.NUM_SRC(2), .IN_W(16), .OUT_W(32)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_src_data(src_data), .i_sel(sel), .i_mode(mode), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_sel_err(out_sel_err)
  );

  mux_extend_pipe #(.NUM_SRC(3), .IN_W(16), .OUT_W(32), .SEL_W(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_src_data(b_src_data), .i_sel(b_sel), .i_mode(b_mode), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready), .o_out_data(b_out_data), .o_out_sel_err(b_out_sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] src, input logic s,
                                        input logic [1:0] md);
    logic [15:0] v;
    logic [31:0] sx;
    v  = s ? src[31:16] : src[15:0];
    sx = {{16{v[15]}}, v};
    case (md)
      2'd0:    return {16'h0000, v};
      2'd1:    return sx;
      2'd2:    return {v, 16'h0000};
      default: return sx << 2;
    endcase
  endfunction

  logic [31:0] q[$];
  logic [31:0] xdata, held, exp_new;
  logic        acc, xf, stall;
  int          sent, rcvd;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; src_data = '0; sel = '0; mode = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_src_data = '0; b_sel = '0; b_mode = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_sel_err", 32'(out_sel_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single sign-extended beat from source 1
    src_data = {16'h8001, 16'h0000}; sel = 1'b1; mode = 2'b01;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_data", out_data, 32'hFFFF8001);
    chk("one_err", 32'(out_sel_err), 32'd0);
    step();
    chk("one_drained", 32'(out_valid), 32'd0);

    // Mode sweep, back-to-back with no bubbles
    src_data = {16'h0000, 16'hF00F}; sel = 1'b0; in_valid = 1'b1;
    mode = 2'b00; step();
    chk("sweep_v0", 32'(out_valid), 32'd1); chk("sweep_m00", out_data, 32'h0000F00F);
    mode = 2'b01; step();
    chk("sweep_v1", 32'(out_valid), 32'd1); chk("sweep_m01", out_data, 32'hFFFFF00F);
    mode = 2'b10; step();
    chk("sweep_v2", 32'(out_valid), 32'd1); chk("sweep_m10", out_data, 32'hF00F0000);
    mode = 2'b11; step();
    chk("sweep_v3", 32'(out_valid), 32'd1); chk("sweep_m11", out_data, 32'hFFFFC03C);
    in_valid = 1'b0; step();
    chk("sweep_end", 32'(out_valid), 32'd0);

    // Backpressure: A, B fill the buffer, C is ignored
    out_ready = 1'b0; mode = 2'b00; sel = 1'b0;
    src_data = 32'h0000_0001; in_valid = 1'b1; step();
    chk("bp_a_data", out_data, 32'h00000001);
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    src_data = 32'h0000_0002; step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_data", out_data, 32'h00000001);
    src_data = 32'h0000_0003; step();
    chk("bp_c_ignored_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_data", out_data, 32'h00000001);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_b_data", out_data, 32'h00000002);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    step();
    chk("bp_no_c", 32'(out_valid), 32'd0);

    // Out-of-range select on the 3-source instance
    b_src_data = {48{1'b1}}; b_sel = 2'd3; b_mode = 2'b01; b_in_valid = 1'b1; step();
    chk("sel3_valid", 32'(b_out_valid), 32'd1);
    chk("sel3_data", b_out_data, 32'h00000000);
    chk("sel3_err", 32'(b_out_sel_err), 32'd1);
    b_sel = 2'd2; step();
    chk("sel2_data", b_out_data, 32'hFFFFFFFF);
    chk("sel2_err", 32'(b_out_sel_err), 32'd0);
    b_in_valid = 1'b0; step();

    // Asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; src_data = 32'h0000_1234; step();
    src_data = 32'h0000_5678; step();
    chk("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_err", 32'(out_sel_err), 32'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1; step();
    chk("mid_post_valid", 32'(out_valid), 32'd0);
    chk("mid_post_ready", 32'(in_ready), 32'd1);

    // Random valid/ready traffic against a FIFO reference
    sent = 0; rcvd = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || q.size() != 0); cyc++) begin
      if (sent < 1000 && (!in_valid || acc)) begin
        if ($urandom_range(0, 2) != 0) begin
          in_valid = 1'b1;
          src_data = $urandom;
          sel      = 1'($urandom_range(0, 1));
          mode     = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
        end
      end else if (acc) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc     = in_valid && in_ready;
      xf      = out_valid && out_ready;
      xdata   = out_data;
      stall   = out_valid && !out_ready;
      held    = out_data;
      exp_new = model(src_data, sel, mode);
      step();
      if (xf) begin
        chk("rand_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rand_order", xdata, q.pop_front());
        rcvd++;
      end
      if (acc) begin
        q.push_back(exp_new);
        sent++;
      end
      if (stall) begin
        chk("rand_stall_valid", 32'(out_valid), 32'd1);
        chk("rand_stall_data", out_data, held);
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_rcvd", 32'(rcvd), 32'd1000);
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
